// File: rtl/conv_engine_pkg.sv
// Shared types and elaboration-time helpers for the convolution engine.
package conv_engine_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StAcc,
    StStore,
    StFin
  } state_e;

  // Ceiling log2, never below 1 so derived widths stay non-zero.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r++;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  // Saturation bounds for a signed result of width dw.
  function automatic longint sat_hi(input int unsigned dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int unsigned dw);
    return -(longint'(1) << (dw - 1));
  endfunction

  // ReLU clamps negative results to this floor.
  localparam longint ReluFloor = 0;

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with output shift, optional ReLU and saturation.
module conv_mac
  import conv_engine_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACCW  = 20,
  parameter int unsigned SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] pixel,
  input  logic signed [DW-1:0] tap,
  input  logic                 relu_en,
  output logic signed [DW-1:0] result
);

  localparam logic signed [ACCW-1:0] SatHi = ACCW'(sat_hi(DW));
  localparam logic signed [ACCW-1:0] SatLo = ACCW'(sat_lo(DW));
  localparam logic signed [ACCW-1:0] Floor = ACCW'(ReluFloor);

  logic signed [2*DW-1:0] mul;
  logic signed [ACCW-1:0] prod;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] shifted, clipped;

  assign mul  = pixel * tap;
  assign prod = ACCW'(mul);

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Result is combinational off the settled accumulator; it only matters during STORE.
  always_comb begin
    shifted = acc_q >>> SHIFT;
    clipped = shifted;
    if (relu_en && shifted[ACCW-1]) clipped = Floor;
    if (clipped > SatHi) begin
      clipped = SatHi;
    end else if (clipped < SatLo) begin
      clipped = SatLo;
    end
  end

  assign result = clipped[DW-1:0];

endmodule

// File: rtl/conv_engine.sv
// Valid-mode 2D convolution engine: fetches each KxK window from an external
// synchronous-read image memory and emits one saturated result per window.
module conv_engine
  import conv_engine_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned H      = 28,
  parameter int unsigned W      = 28,
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned SHIFT  = 0,
  localparam int unsigned OH    = (H - K) / STRIDE + 1,
  localparam int unsigned OW    = (W - K) / STRIDE + 1,
  localparam int unsigned AW    = clog2(H * W),
  localparam int unsigned OAW   = clog2(OH * OW),
  localparam int unsigned ACCW  = 2 * DW + clog2(K * K)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   relu_en,
  input  logic [K*K*DW-1:0]      kernel_flat,
  output logic [AW-1:0]          mem_addr,
  input  logic signed [DW-1:0]   mem_data,
  input  logic                   stall,
  output logic signed [DW-1:0]   result,
  output logic [OAW-1:0]         address,
  output logic                   store,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned KCW = clog2(K + 1);
  localparam int unsigned TW  = clog2(K * K + 1);
  localparam int unsigned RW  = clog2(OH + 1);
  localparam int unsigned CW  = clog2(OW + 1);

  state_e              state_q, state_d;
  logic [K*K*DW-1:0]   kernel_q, kernel_d;
  logic                relu_q, relu_d;
  logic [RW-1:0]       orow_q, orow_d;
  logic [CW-1:0]       ocol_q, ocol_d;
  logic [KCW-1:0]      kr_q, kr_d;
  logic [KCW-1:0]      kc_q, kc_d;
  logic [TW-1:0]       tidx_q, tidx_d;
  logic [TW-1:0]       tap_q;
  logic                vld_q;
  logic                clr;
  logic signed [DW-1:0] tap;

  always_comb begin
    state_d  = state_q;
    kernel_d = kernel_q;
    relu_d   = relu_q;
    orow_d   = orow_q;
    ocol_d   = ocol_q;
    kr_d     = kr_q;
    kc_d     = kc_q;
    tidx_d   = tidx_q;
    clr      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          kernel_d = kernel_flat;
          relu_d   = relu_en;
          clr      = 1'b1;
          orow_d   = '0;
          ocol_d   = '0;
          kr_d     = '0;
          kc_d     = '0;
          tidx_d   = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        if (kc_q == KCW'(K - 1)) begin
          kc_d = '0;
          kr_d = (kr_q == KCW'(K - 1)) ? '0 : kr_q + 1'b1;
        end else begin
          kc_d = kc_q + 1'b1;
        end
        if (tidx_q == TW'(K * K - 1)) begin
          tidx_d  = '0;
          state_d = StAcc;
        end else begin
          tidx_d = tidx_q + 1'b1;
        end
      end
      StAcc: state_d = StStore;
      StStore: begin
        if (!stall) begin
          clr = 1'b1;
          if (ocol_q == CW'(OW - 1)) begin
            ocol_d = '0;
            if (orow_q == RW'(OH - 1)) begin
              orow_d  = '0;
              state_d = StFin;
            end else begin
              orow_d  = orow_q + 1'b1;
              state_d = StFetch;
            end
          end else begin
            ocol_d  = ocol_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      kernel_q <= '0;
      relu_q   <= 1'b0;
      orow_q   <= '0;
      ocol_q   <= '0;
      kr_q     <= '0;
      kc_q     <= '0;
      tidx_q   <= '0;
      tap_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kernel_q <= kernel_d;
      relu_q   <= relu_d;
      orow_q   <= orow_d;
      ocol_q   <= ocol_d;
      kr_q     <= kr_d;
      kc_q     <= kc_d;
      tidx_q   <= tidx_d;
      // Memory returns data one cycle after the address, so the tap index lags by one.
      tap_q    <= tidx_q;
      vld_q    <= (state_q == StFetch);
    end
  end

  assign tap = kernel_q[32'(tap_q) * DW +: DW];

  assign mem_addr = AW'((32'(orow_q) * STRIDE + 32'(kr_q)) * W
                        + 32'(ocol_q) * STRIDE + 32'(kc_q));
  assign address  = OAW'(32'(orow_q) * OW + 32'(ocol_q));
  assign store    = (state_q == StStore);
  assign done     = (state_q == StFin);
  assign busy     = (state_q != StIdle);

  conv_mac #(
    .DW    (DW),
    .ACCW  (ACCW),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .en      (vld_q),
    .pixel   (mem_data),
    .tap     (tap),
    .relu_en (relu_q),
    .result  (result)
  );

endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine: 4x4 stride-1 and 5x5 stride-2 instances.
module tb_conv_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, relu, stall;
  logic [71:0] kern;

  logic [3:0]  mem_addr_a;
  logic [7:0]  mem_data_a, result_a;
  logic [1:0]  address_a;
  logic        store_a, busy_a, done_a;

  logic [4:0]  mem_addr_b;
  logic [7:0]  mem_data_b, result_b;
  logic [1:0]  address_b;
  logic        store_b, busy_b, done_b;

  logic [7:0]  img_a [16];
  logic [7:0]  img_b [25];

  logic        use_b;
  logic        m_store, m_busy, m_done;
  logic [7:0]  m_result;
  logic [1:0]  m_address;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_data_a <= img_a[mem_addr_a];
  always @(posedge clk) mem_data_b <= img_b[mem_addr_b];

  assign m_store   = use_b ? store_b   : store_a;
  assign m_busy    = use_b ? busy_b    : busy_a;
  assign m_done    = use_b ? done_b    : done_a;
  assign m_result  = use_b ? result_b  : result_a;
  assign m_address = use_b ? address_b : address_a;

  conv_engine #(.DW(8), .H(4), .W(4), .K(3), .STRIDE(1), .SHIFT(0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .relu_en(relu), .kernel_flat(kern),
    .mem_addr(mem_addr_a), .mem_data(mem_data_a), .stall(stall), .result(result_a),
    .address(address_a), .store(store_a), .busy(busy_a), .done(done_a)
  );

  conv_engine #(.DW(8), .H(5), .W(5), .K(3), .STRIDE(2), .SHIFT(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .relu_en(relu), .kernel_flat(kern),
    .mem_addr(mem_addr_b), .mem_data(mem_data_b), .stall(stall), .result(result_b),
    .address(address_b), .store(store_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one frame; n counts negedges after the posedge that accepted start.
  task automatic run_frame(input logic sel, input logic [71:0] k, input logic r,
                           input int stall_idx, input logic [3:0][7:0] exp_res,
                           input int exp_done);
    int         nst;
    int         left;
    logic       prev;
    logic       seen_done;
    logic [7:0] hold_res;
    logic [1:0] hold_addr;
    use_b = sel;
    kern  = k;
    relu  = r;
    stall = 1'b0;
    @(negedge clk);
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    kern    = ~k;
    relu    = ~r;
    chk("busy_after_start", m_busy, 1);
    nst = 0; left = 0; prev = 1'b0; seen_done = 1'b0;
    hold_res = '0; hold_addr = '0;
    for (int n = 0; n < 150 && !seen_done; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 3) begin
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
      end
      if (n == 4) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if (left > 0) begin
        chk("stall_store_held", m_store, 1);
        chk("stall_result_held", m_result, hold_res);
        chk("stall_address_held", m_address, hold_addr);
        left--;
        if (left == 0) stall = 1'b0;
      end else if (m_store && !prev) begin
        chk("store_cycle", n, 10 + 11 * nst + ((stall_idx >= 0 && nst > stall_idx) ? 5 : 0));
        if (nst < 4) chk("result", m_result, exp_res[nst]);
        chk("address", m_address, nst);
        if (nst == stall_idx) begin
          stall     = 1'b1;
          left      = 5;
          hold_res  = m_result;
          hold_addr = m_address;
        end
        nst++;
      end
      if (m_done) begin
        chk("done_cycle", n, exp_done);
        seen_done = 1'b1;
      end
      prev = m_store;
    end
    chk("done_seen", seen_done, 1);
    chk("store_count", nst, 4);
    @(negedge clk);
    chk("done_one_cycle", m_done, 0);
    chk("idle_after_done", m_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; relu = 1'b0; stall = 1'b0;
    kern = '0; use_b = 1'b0;
    for (int i = 0; i < 16; i++) img_a[i] = 8'd1;
    for (int i = 0; i < 25; i++) img_b[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk("reset_store", store_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_result", result_a, 0);
    chk("reset_address", address_a, 0);
    chk("reset_mem_addr", mem_addr_a, 0);
    rst = 1'b1;
    @(negedge clk);

    // All-ones image and kernel: 9 per window.
    run_frame(1'b0, {9{8'h01}}, 1'b0, -1, {4{8'd9}}, 44);
    // Negative kernel, with and without ReLU.
    run_frame(1'b0, {9{8'hFF}}, 1'b0, -1, {4{8'hF7}}, 44);
    run_frame(1'b0, {9{8'hFF}}, 1'b1, -1, {4{8'h00}}, 44);
    // Saturation both ways.
    for (int i = 0; i < 16; i++) img_a[i] = 8'd127;
    run_frame(1'b0, {9{8'h7F}}, 1'b0, -1, {4{8'h7F}}, 44);
    run_frame(1'b0, {9{8'h80}}, 1'b0, -1, {4{8'h80}}, 44);
    // Stall on the second store stretches the frame by 5 cycles.
    for (int i = 0; i < 16; i++) img_a[i] = 8'd1;
    run_frame(1'b0, {9{8'h01}}, 1'b0, 1, {4{8'd9}}, 49);
    // Stride 2 on the 5x5 instance, centre tap only.
    run_frame(1'b1, 72'h00_00_00_00_01_00_00_00_00, 1'b0, -1,
              {8'd18, 8'd16, 8'd8, 8'd6}, 44);

    // Reset during the third window's fetch.
    use_b = 1'b0;
    kern  = {9{8'h01}};
    relu  = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (24) @(negedge clk);
    chk("busy_before_reset", busy_a, 1);
    rst = 1'b0;
    #1;
    chk("midreset_store", store_a, 0);
    chk("midreset_done", done_a, 0);
    chk("midreset_busy", busy_a, 0);
    chk("midreset_result", result_a, 0);
    chk("midreset_address", address_a, 0);
    chk("midreset_mem_addr", mem_addr_a, 0);
    @(negedge clk);
    rst   = 1'b1;
    stray = 0;
    repeat (60) begin
      @(negedge clk);
      if (store_a || done_a || busy_a) stray++;
    end
    chk("quiet_after_reset", stray, 0);
    run_frame(1'b0, {9{8'h01}}, 1'b0, -1, {4{8'd9}}, 44);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
